// File: rtl/ps2_kbd_rx_pkg.sv
// Shared PS/2 keyboard constants and the frame FSM state type.
// main_ctrl imports this package for its key constants too.
package ps2_pkg;

    localparam logic [7:0]  PS2_BRK        = 8'hF0;
    localparam logic [7:0]  PS2_EXT        = 8'hE0;
    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } frame_state_e;

    // Odd parity over 8 data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [8:0] i_bits);
        return ^i_bits;
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Decoded keyboard output bus from ps2_kbd_rx towards main_ctrl.
interface ps2_kbd_rx_if;

    logic [7:0] ps2_byte;
    logic       ps2_state;
    logic       ps2_ext;
    logic       ps2_err;

    modport master (output ps2_byte, output ps2_state, output ps2_ext, output ps2_err);
    modport slave  (input  ps2_byte, input  ps2_state, input  ps2_ext, input  ps2_err);

endinterface

// File: rtl/ps2_kbd_rx_frame_rx.sv
// PS/2 pin synchroniser, 11-bit frame deserialiser with parity/stop check and
// inter-edge timeout. o_byte_valid / o_frame_err are single-cycle, never together.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err
);

    localparam logic [3:0]  STOP_IDX = 4'(PS2_FRAME_BITS - 2);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]   r_clk_sync;
    logic [1:0]   r_dat_sync;
    frame_state_e r_state, w_state_nxt;
    logic [3:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [8:0]   r_shreg, w_shreg_nxt;
    logic [15:0]  r_timer, w_timer_nxt;
    logic         w_fall;
    logic         w_data;

    assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_data = r_dat_sync[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_timer    <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shreg    <= w_shreg_nxt;
            r_timer    <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        w_timer_nxt   = r_timer;
        o_byte_valid  = 1'b0;
        o_frame_err   = 1'b0;
        o_byte_data   = r_shreg[7:0];

        case (r_state)
            ST_IDLE: begin
                w_timer_nxt = '0;
                if (w_fall && !w_data) begin
                    w_state_nxt   = ST_RECV;
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_RECV: begin
                if (w_fall) begin
                    w_timer_nxt = '0;
                    if (r_bit_cnt == STOP_IDX) begin
                        // Current data is the stop bit; shreg holds data + parity.
                        w_state_nxt = ST_IDLE;
                        if (odd_parity_ok(r_shreg) && w_data)
                            o_byte_valid = 1'b1;
                        else
                            o_frame_err = 1'b1;
                    end else begin
                        w_shreg_nxt   = {w_data, r_shreg[8:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end else if (r_timer == TMO_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_IDLE;
                    o_frame_err = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: strips F0 (break) and E0 (extended) prefixes and
// strobes each make code out to main_ctrl.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_kbd_rx_if.master   bus
);

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_frame_err;

    logic [7:0] r_byte;
    logic       r_state;
    logic       r_ext_out;
    logic       r_err;
    logic       r_brk;
    logic       r_ext;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_frame_err  (w_frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte    <= '0;
            r_state   <= 1'b0;
            r_ext_out <= 1'b0;
            r_err     <= 1'b0;
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
        end else begin
            r_state <= 1'b0;
            r_err   <= w_frame_err;
            if (w_frame_err) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (w_byte_valid) begin
                if (w_byte_data == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else if (w_byte_data == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_brk) begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end else begin
                    r_byte    <= w_byte_data;
                    r_ext_out <= r_ext;
                    r_state   <= 1'b1;
                    r_ext     <= 1'b0;
                end
            end
        end
    end

    assign bus.ps2_byte  = r_byte;
    assign bus.ps2_state = r_state;
    assign bus.ps2_ext   = r_ext_out;
    assign bus.ps2_err   = r_err;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed frames plus randomized traffic
// against a byte-level decoder model.
module tb_ps2_kbd_rx;

    localparam int unsigned TMO = 200;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;

    ps2_kbd_rx_if bus();

    ps2_kbd_rx #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    logic        rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Output monitor, sampled on the falling clk edge.
    int unsigned n_state = 0, n_err = 0, n_both = 0, n_glitch = 0;
    int unsigned st_cyc = 0, er_cyc = 0;
    logic [7:0]  prev_byte = 8'h00;
    logic        prev_ext  = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ps2_state) begin n_state++; st_cyc = cyc; end
            if (bus.ps2_err)   begin n_err++;   er_cyc = cyc; end
            if (bus.ps2_state && bus.ps2_err) n_both++;
            if (!rst_q && !bus.ps2_state &&
                (bus.ps2_byte != prev_byte || bus.ps2_ext != prev_ext)) n_glitch++;
        end
        prev_byte = bus.ps2_byte;
        prev_ext  = bus.ps2_ext;
    end

    // Reference decoder state.
    logic       m_brk = 1'b0, m_ext = 1'b0, m_xout = 1'b0;
    logic [7:0] m_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int unsigned h, input int unsigned first, input int unsigned last,
                             output int unsigned lf);
        logic [10:0] frame;
        frame = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        lf = cyc;
        for (int unsigned i = first; i <= last; i++) begin
            @(posedge clk); #1 ps2_data = frame[i];
            repeat (h) @(posedge clk);
            #1 ps2_clk = 1'b0;
            lf = cyc;
            repeat (h) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        @(posedge clk); #1 ps2_data = 1'b1;
    endtask

    task automatic frame_check(input string tag, input logic [7:0] b, input bit bad_par,
                               input bit bad_stop, input int unsigned h);
        int unsigned s0, e0, lf;
        int unsigned exp_state, exp_err;
        exp_state = 0;
        exp_err   = 0;
        if (bad_par || bad_stop) begin
            exp_err = 1; m_brk = 1'b0; m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (m_brk) begin
            m_brk = 1'b0; m_ext = 1'b0;
        end else begin
            exp_state = 1; m_byte = b; m_xout = m_ext; m_ext = 1'b0;
        end
        s0 = n_state;
        e0 = n_err;
        send_bits(b, bad_par, bad_stop, h, 0, 10, lf);
        repeat (8) @(posedge clk);
        #1;
        check({tag, ".strobes"}, n_state - s0, exp_state);
        check({tag, ".errs"},    n_err - e0,   exp_err);
        check({tag, ".byte"},    {24'h0, bus.ps2_byte}, {24'h0, m_byte});
        check({tag, ".ext"},     {31'h0, bus.ps2_ext},  {31'h0, m_xout});
        if (exp_state != 0) check({tag, ".st_lat"}, st_cyc - lf, 3);
        if (exp_err != 0)   check({tag, ".er_lat"}, er_cyc - lf, 3);
    endtask

    initial begin
        int unsigned s0, e0, lf, d, r;
        logic [7:0] b;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst.byte",  {24'h0, bus.ps2_byte}, 32'h0);
        check("rst.state", {31'h0, bus.ps2_state}, 32'h0);
        check("rst.ext",   {31'h0, bus.ps2_ext},   32'h0);
        check("rst.err",   {31'h0, bus.ps2_err},   32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        frame_check("make23",   8'h23, 0, 0, 40);
        frame_check("brkF0",    8'hF0, 0, 0, 40);
        frame_check("rel23",    8'h23, 0, 0, 40);
        frame_check("extE0",    8'hE0, 0, 0, 40);
        frame_check("make75",   8'h75, 0, 0, 40);
        frame_check("xrelE0",   8'hE0, 0, 0, 20);
        frame_check("xrelF0",   8'hF0, 0, 0, 20);
        frame_check("xrel75",   8'h75, 0, 0, 20);
        frame_check("make1D",   8'h1D, 0, 0, 20);
        frame_check("badpar23", 8'h23, 1, 0, 10);
        frame_check("make1C",   8'h1C, 0, 0, 10);
        frame_check("badstop",  8'h44, 0, 1, 10);

        // Clock stops after 5 bits: timeout error, then a clean frame.
        s0 = n_state; e0 = n_err;
        send_bits(8'h29, 0, 0, 10, 0, 4, lf);
        repeat (TMO + 60) @(posedge clk);
        #1;
        d = er_cyc - lf;
        check("tmo.errs",    n_err - e0, 1);
        check("tmo.strobes", n_state - s0, 0);
        check("tmo.lat",     {31'h0, (d >= TMO - 1 && d <= TMO + 4)}, 1);
        frame_check("make29", 8'h29, 0, 0, 10);

        // Reset in the middle of a frame.
        s0 = n_state;
        send_bits(8'h23, 0, 0, 10, 0, 4, lf);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("midrst.byte",  {24'h0, bus.ps2_byte}, 32'h0);
        check("midrst.state", {31'h0, bus.ps2_state}, 32'h0);
        check("midrst.ext",   {31'h0, bus.ps2_ext},   32'h0);
        check("midrst.err",   {31'h0, bus.ps2_err},   32'h0);
        m_brk = 1'b0; m_ext = 1'b0; m_byte = 8'h00; m_xout = 1'b0;
        send_bits(8'h23, 0, 0, 10, 5, 10, lf);
        repeat (TMO + 60) @(posedge clk);
        #1;
        check("midrst.strobes", n_state - s0, 0);
        frame_check("postrst23", 8'h23, 0, 0, 10);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      b = 8'hF0;
            else if (r < 35) b = 8'hE0;
            else             b = 8'($urandom);
            r = $urandom_range(0, 99);
            frame_check($sformatf("rnd%0d", i), b, (r < 8), (r >= 8 && r < 12),
                        $urandom_range(4, 40));
        end

        check("never_both",     n_both,   0);
        check("byte_only_on_strobe", n_glitch, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard receiver sitting directly upstream of `main_ctrl`. It samples the raw keyboard clock and data pins, deserialises 11-bit device-to-host frames and checks them, then strips the break (F0) and extended (E0) prefixes. For each key press it presents the make code on `ps2_byte` with a one-cycle `ps2_state` strobe, which `main_ctrl` consumes as its command input.

## Interface
- `TIMEOUT_CYCLES`, default 50000: idle clk cycles allowed between PS/2 falling edges inside a frame before the frame is abandoned (2 ms at 25 MHz).
- `clk` input 1: system clock, 25 MHz nominal, single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `ps2_clk` input 1: raw keyboard clock pin, asynchronous.
- `ps2_data` input 1: raw keyboard data pin, asynchronous.
- `ps2_byte` output 8: last accepted make code; holds until the next one is accepted.
- `ps2_state` output 1: one-cycle strobe, high in the cycle `ps2_byte` updates.
- `ps2_ext` output 1: high if the make code in `ps2_byte` was E0-prefixed; updates with `ps2_byte`.
- `ps2_err` output 1: one-cycle strobe on a parity, stop-bit or timeout error.

## Operation
- Synchroniser: a 3-flop chain on `ps2_clk` (s1, s2, s3) and a 2-flop chain on `ps2_data`. `fall = s3 & ~s2`. Data is sampled from its second flop when `fall` is high.
- Frame FSM:
  - IDLE: on `fall` with data 0, this is the start bit; go to RECV with bit_cnt=0. On `fall` with data 1, ignore and stay in IDLE.
  - RECV: each `fall` shifts data into shreg LSB-first and increments bit_cnt. Bits 0–7 are data, bit 8 is parity, bit 9 is stop.
  - When bit_cnt reaches 9 on a `fall`, check the frame:
    - odd parity: XOR of the 8 data bits and the parity bit must equal 1;
    - stop bit must equal 1.
  - Pass: hand the byte to the decoder and return to IDLE. Fail: pulse `ps2_err`, clear `brk` and `ext`, return to IDLE.
- Timeout: a 16-bit counter clears on every `fall` and increments in RECV. When it reaches `TIMEOUT_CYCLES-1` with no `fall`, pulse `ps2_err`, clear the prefix flags and go to IDLE. If `fall` and timeout occur in the same cycle, `fall` wins.
- Decoder, applied to each valid byte:
  - F0: set `brk`.
  - E0: set `ext`.
  - Any other byte with `brk` set: this is a release. Clear `brk` and `ext`; no strobe.
  - Any other byte with `brk` clear: this is a press. Load `ps2_byte`, load `ps2_ext` from `ext`, pulse `ps2_state`, then clear `ext`.
- Typematic repeats are repeated make codes, so each one produces its own strobe.
- Reset values: `ps2_byte`=8'h00, `ps2_state`=0, `ps2_ext`=0, `ps2_err`=0, FSM=IDLE, `brk`=`ext`=0, counters 0.
- Reset asserted mid-frame discards the partial frame. The next frame is accepted only from a fresh start bit.

## Timing
- Pin-to-`fall` latency: a pin falling before clk edge k gives `fall` high in the cycle after edge k+1.
- `ps2_state` and `ps2_err` are registered at edge k+2, where k is the edge sampling the stop-bit falling edge. They are high for exactly one cycle.
- `ps2_byte` and `ps2_ext` change only at edges where `ps2_state` is registered high.
- The two strobes never fire in the same cycle.
- Prefix bytes (F0, E0) and release codes produce no output activity.
- Minimum PS/2 half-period handled: 4 clk cycles. Real keyboards run at 30–50 µs, well above this.

## Structure
- `ps2_pkg` holds:
  - `PS2_BRK` = 8'hF0 and `PS2_EXT` = 8'hE0;
  - `PS2_FRAME_BITS` = 11;
  - the frame FSM state enum.
  `main_ctrl` should use the same package for its key constants.
- Sub-module `ps2_frame_rx` contains the synchroniser, the frame FSM, parity/stop checking and the timeout. It outputs `byte_valid`, `byte_data` and `frame_err`.
- The top level `ps2_kbd_rx` contains only the prefix decoder and the output registers.

## Test plan
- Send frame 8'h23 (data bits LSB-first, parity 0, stop 1) at a 40-cycle half-period → `ps2_byte`=8'h23 and `ps2_state` high for 1 cycle, 3 edges after the stop-bit fall; `ps2_ext`=0; `ps2_err` stays 0.
- Send F0 then 23 → no strobe, `ps2_byte` remains 8'h23. Then E0,75 → strobe with `ps2_byte`=8'h75, `ps2_ext`=1.
- Send E0,F0,75 (extended release), then 1D → one strobe only, `ps2_byte`=8'h1D, `ps2_ext`=0.
- Send 8'h23 with its parity bit flipped → `ps2_err` pulses once, no `ps2_state`. The following good 8'h1C frame → strobe with 8'h1C.
- With `TIMEOUT_CYCLES`=200, stop the PS/2 clock after 5 bits → `ps2_err` pulses 200 cycles after the last fall. A complete 8'h29 frame afterwards is accepted.
- Assert `rst` for 1 cycle in the middle of a frame → all outputs 0. The remaining bits produce no strobe (the next fall has data 1 or the frame times out). The next full frame 8'h23 → strobe.
